// File: rtl/disp_pkg.sv
// disp_pkg: shared types and seven-segment constants for the display scanner
package disp_pkg;
  typedef enum logic {GUARD, ACTIVE} state_t;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/disp_scan_4_if.sv
// disp_scan_4_if: display data inputs and anode/segment outputs of the scanner
interface disp_scan_4_if;
  logic [15:0] data_i;
  logic [3:0]  dp_i;
  logic        blank_lz_i;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_o;
  modport master (output data_i, dp_i, blank_lz_i, input an_o, seg_o, dp_o, frame_o);
  modport slave  (input data_i, dp_i, blank_lz_i, output an_o, seg_o, dp_o, frame_o);
endinterface

// File: rtl/seg7_dec.sv
// seg7_dec: hex nibble to active-low seven-segment glyph
module seg7_dec
  import disp_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  assign seg_o = GLYPHS[hex_i];
endmodule

// File: rtl/disp_scan_4.sv
// disp_scan_4: four-digit multiplexed seven-segment scanner with anode guard time
module disp_scan_4
  import disp_pkg::*;
#(
  parameter int unsigned GUARD_CYC = 4
) (
  input logic clk_i,
  input logic rst_i,
  input logic tick_i,
  disp_scan_4_if.slave bus
);
  localparam logic [7:0] CNT_INIT = 8'(GUARD_CYC - 1);
  logic        tick_q;
  logic [1:0]  idx_q, idx_d;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  sdp_q, sdp_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_q, frame_d;
  logic        adv, wrap, blank;
  logic [15:0] upper;
  logic [3:0]  nib;
  logic [6:0]  glyph;
  assign upper = shadow_q >> {idx_q, 2'b00};
  assign nib = upper[3:0];
  seg7_dec u_dec (.hex_i(nib), .seg_o(glyph));
  // next state; outputs decode from the next FSM state so the digit lights on the transition edge
  always_comb begin
    adv = tick_i & ~tick_q;
    wrap = adv && idx_q == 2'd3;
    idx_d = adv ? idx_q + 2'd1 : idx_q;
    shadow_d = wrap ? bus.data_i : shadow_q;
    sdp_d = wrap ? bus.dp_i : sdp_q;
    frame_d = wrap;
    cnt_d = adv ? CNT_INIT : (state_q == GUARD && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    state_d = adv ? GUARD : (state_q == GUARD && cnt_q == 8'd0) ? ACTIVE : state_q;
    blank = bus.blank_lz_i && idx_q != 2'd0 && upper == 16'h0;
    an_d = state_d == ACTIVE ? ~(4'b0001 << idx_q) : 4'hF;
    seg_d = (state_d == ACTIVE && !blank) ? glyph : SEG_OFF;
    dp_d = state_d == ACTIVE ? ~sdp_q[idx_q] : 1'b1;
  end
  // state and registered outputs; reset wins over any advance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_q   <= 1'b0;
      idx_q    <= 2'd0;
      state_q  <= GUARD;
      cnt_q    <= CNT_INIT;
      shadow_q <= 16'h0;
      sdp_q    <= 4'h0;
      an_q     <= 4'hF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      tick_q   <= tick_i;
      idx_q    <= idx_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
    end
  end
  assign bus.an_o = an_q;
  assign bus.seg_o = seg_q;
  assign bus.dp_o = dp_q;
  assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_disp_scan_4.sv
// tb_disp_scan_4: randomized scan stimulus checked against a cycles-since-advance model
module tb_disp_scan_4;
  localparam int G = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  disp_scan_4_if bus();
  disp_scan_4 #(.GUARD_CYC(G)) dut (.clk_i(clk), .rst_i(rst), .tick_i(tick), .bus(bus));
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int glyph [16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                     'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};
  int          m_idx = 0;
  int          since = 0;
  logic        m_tick = 1'b0;
  logic [15:0] m_data = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic        m_frame = 1'b0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_edge();
    logic adv;
    logic lit;
    logic [15:0] above;
    if (rst) begin
      m_idx = 0; m_tick = 1'b0; m_data = 16'h0; m_dp = 4'h0; since = 0; m_frame = 1'b0;
    end else begin
      adv = tick && !m_tick;
      m_tick = tick;
      m_frame = adv && m_idx == 3;
      if (adv) begin
        if (m_idx == 3) begin
          m_data = bus.data_i;
          m_dp = bus.dp_i;
        end
        m_idx = (m_idx + 1) % 4;
        since = 0;
      end else if (since < 1000) since++;
    end
    lit = since >= G;
    above = m_data >> (4 * m_idx);
    e_an = lit ? ~(4'b0001 << m_idx) : 4'hF;
    e_seg = (!lit || (bus.blank_lz_i && m_idx > 0 && above == 16'h0)) ? 7'h7F : 7'(glyph[above[3:0]]);
    e_dp = lit ? !m_dp[m_idx] : 1'b1;
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("an", 16'(bus.an_o), 16'(e_an));
    check("seg", 16'(bus.seg_o), 16'(e_seg));
    check("dp", 16'(bus.dp_o), 16'(e_dp));
    check("frame", 16'(bus.frame_o), 16'(m_frame));
  endtask
  task automatic rises(int n, int half);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      repeat (half) cyc();
      tick = 1'b0;
      repeat (half) cyc();
    end
  endtask
  initial begin
    bus.data_i = 16'h0;
    bus.dp_i = 4'h0;
    bus.blank_lz_i = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    repeat (12) cyc();
    bus.data_i = 16'h12AF;
    bus.dp_i = 4'b0100;
    rises(12, 8);
    bus.data_i = 16'h0050;
    bus.dp_i = 4'h0;
    bus.blank_lz_i = 1'b1;
    rises(8, 8);
    bus.blank_lz_i = 1'b0;
    rises(8, 8);
    for (int i = 0; i < 32; i++) begin
      tick = ~tick;
      repeat (2) cyc();
    end
    tick = 1'b1;
    repeat (30) cyc();
    tick = 1'b0;
    repeat (30) cyc();
    tick = 1'b1;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    tick = 1'b0;
    repeat (10) cyc();
    for (int i = 0; i < 300; i++) begin
      tick = ~tick;
      if ($urandom_range(0, 3) == 0) bus.data_i = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) bus.dp_i = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus.blank_lz_i = ~bus.blank_lz_i;
      if ($urandom_range(0, 49) == 0) rst = 1'b1;
      repeat ($urandom_range(1, 12)) cyc();
      rst = 1'b0;
    end
    repeat (10) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
